// File: rtl/chroma_phase_gen.sv
// Chroma phase/amplitude generator feeding the sine LUT: subcarrier phase accumulator,
// per-line colour burst insertion, hue/saturation during active video, PAL V-switch.
module chroma_phase_gen #(
    parameter int ACC_WIDTH   = 32,
    parameter int CNT_WIDTH   = 11,
    parameter int BURST_START = 80,
    parameter int BURST_LEN   = 40,
    parameter int BURST_AMP   = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ACC_WIDTH-1:0] phase_inc,
    input  logic                 pal_mode,
    input  logic                 line_start,
    input  logic                 frame_start,
    input  logic                 active,
    input  logic [4:0]           hue,
    input  logic signed [5:0]    saturation,
    output logic [4:0]           phase,
    output logic signed [5:0]    amplitude,
    output logic                 burst,
    output logic                 v_switch
);

    localparam logic [CNT_WIDTH-1:0] BURST_LO = CNT_WIDTH'(BURST_START);
    localparam logic [CNT_WIDTH-1:0] BURST_HI = CNT_WIDTH'(BURST_START + BURST_LEN);
    localparam logic signed [5:0]    BAMP     = 6'(BURST_AMP);

    logic [ACC_WIDTH-1:0] acc;
    logic [CNT_WIDTH-1:0] cnt;
    logic [ACC_WIDTH-1:0] inc_l;
    logic                 pal_l;
    logic                 vsw;

    logic [4:0]           acc_ph;
    logic                 in_burst;
    logic [4:0]           burst_off;
    logic [4:0]           hue_off;
    logic [4:0]           nxt_phase;
    logic signed [5:0]    nxt_amp;
    logic                 nxt_burst;

    // Counter resets to all-ones so no burst is emitted before the first line_start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            cnt   <= '1;
            inc_l <= '0;
            pal_l <= 1'b0;
            vsw   <= 1'b0;
        end else begin
            acc <= frame_start ? '0 : acc + inc_l;

            if (line_start || frame_start)
                cnt <= '0;
            else if (cnt != '1)
                cnt <= cnt + CNT_WIDTH'(1);

            if (line_start) begin
                inc_l <= phase_inc;
                pal_l <= pal_mode;
            end

            if (frame_start)
                vsw <= 1'b0;
            else if (line_start)
                vsw <= pal_mode & ~vsw;
        end
    end

    always_comb begin
        acc_ph    = acc[ACC_WIDTH-1 -: 5];
        in_burst  = (cnt >= BURST_LO) && (cnt < BURST_HI);
        burst_off = !pal_l ? 5'd16 : (vsw ? 5'd20 : 5'd12);
        hue_off   = (pal_l && vsw) ? (~hue + 5'd1) : hue;

        nxt_phase = acc_ph;
        nxt_amp   = '0;
        nxt_burst = 1'b0;
        if (in_burst) begin
            nxt_phase = acc_ph + burst_off;
            nxt_amp   = BAMP;
            nxt_burst = 1'b1;
        end else if (active) begin
            nxt_phase = acc_ph + hue_off;
            nxt_amp   = saturation;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase     <= '0;
            amplitude <= '0;
            burst     <= 1'b0;
        end else begin
            phase     <= nxt_phase;
            amplitude <= nxt_amp;
            burst     <= nxt_burst;
        end
    end

    assign v_switch = vsw;

endmodule

// File: tb/tb_chroma_phase_gen.sv
// Directed self-checking bench for chroma_phase_gen.
module tb_chroma_phase_gen;

    logic              clk;
    logic              rst_n;
    logic [31:0]       phase_inc;
    logic              pal_mode;
    logic              line_start;
    logic              frame_start;
    logic              active;
    logic [4:0]        hue;
    logic signed [5:0] saturation;
    logic [4:0]        phase;
    logic signed [5:0] amplitude;
    logic              burst;
    logic              v_switch;

    int         checks;
    int         failures;
    logic [4:0] mph;   // expected acc_ph of the current accumulator state

    chroma_phase_gen #(
        .ACC_WIDTH  (32),
        .CNT_WIDTH  (11),
        .BURST_START(80),
        .BURST_LEN  (40),
        .BURST_AMP  (12)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .phase_inc  (phase_inc),
        .pal_mode   (pal_mode),
        .line_start (line_start),
        .frame_start(frame_start),
        .active     (active),
        .hue        (hue),
        .saturation (saturation),
        .phase      (phase),
        .amplitude  (amplitude),
        .burst      (burst),
        .v_switch   (v_switch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int bad;
        rst_n = 1'b0; phase_inc = '0; pal_mode = 1'b0; line_start = 1'b0;
        frame_start = 1'b0; active = 1'b0; hue = '0; saturation = '0;
        repeat (3) tick();
        checks++;
        if (phase !== 5'd0 || amplitude !== 6'sd0 || burst !== 1'b0 || v_switch !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got phase=%0d amp=%0d burst=%0b vsw=%0b exp 0/0/0/0",
                     phase, amplitude, burst, v_switch);
        end
        rst_n = 1'b1;
        phase_inc = 32'h0800_0000;  // never latched: no line_start
        bad = 0;
        for (int k = 0; k < 3000; k++) begin
            tick();
            checks++;
            if (phase !== 5'd0 || amplitude !== 6'sd0 || burst !== 1'b0) begin
                failures++;
                if (bad < 5)
                    $display("FAIL idle_no_line k=%0d got phase=%0d amp=%0d burst=%0b exp 0/0/0",
                             k, phase, amplitude, burst);
                bad++;
            end
        end
    endtask

    task automatic run_line(input string name, input bit pal, input bit act,
                            input logic [4:0] h, input logic signed [5:0] sat,
                            input logic [4:0] boff, input logic [4:0] aoff,
                            input bit exp_vsw, input bit with_frame);
        int first_b, last_b, nb;
        logic [4:0]        ep;
        logic signed [5:0] ea;
        logic              eb;
        phase_inc = 32'h0800_0000; pal_mode = pal; line_start = 1'b1;
        frame_start = with_frame; active = act; hue = h; saturation = sat;
        tick();
        mph = with_frame ? 5'd0 : mph + 5'd1;
        line_start = 1'b0; frame_start = 1'b0;
        checks++;
        if (v_switch !== exp_vsw) begin
            failures++;
            $display("FAIL %s v_switch got=%0b exp=%0b", name, v_switch, exp_vsw);
        end
        first_b = 0; last_b = 0; nb = 0;
        for (int k = 1; k <= 130; k++) begin
            if (k >= 81 && k <= 120) begin
                ep = mph + boff; ea = 6'sd12; eb = 1'b1;
            end else if (act) begin
                ep = mph + aoff; ea = sat; eb = 1'b0;
            end else begin
                ep = mph; ea = 6'sd0; eb = 1'b0;
            end
            tick();
            mph = mph + 5'd1;
            checks++;
            if (phase !== ep || amplitude !== ea || burst !== eb) begin
                failures++;
                $display("FAIL %s k=%0d got phase=%0d amp=%0d burst=%0b exp phase=%0d amp=%0d burst=%0b",
                         name, k, phase, amplitude, burst, ep, ea, eb);
            end
            if (burst === 1'b1) begin
                nb++;
                if (first_b == 0) first_b = k;
                last_b = k;
            end
        end
        checks++;
        if (nb != 40 || first_b != 81 || last_b != 120) begin
            failures++;
            $display("FAIL %s burst_window got len=%0d first=%0d last=%0d exp 40/81/120",
                     name, nb, first_b, last_b);
        end
    endtask

    task automatic test_ntsc();
        run_line("ntsc_plain",  1'b0, 1'b0, 5'd0, 6'sd0,   5'd16, 5'd0, 1'b0, 1'b1);
        run_line("ntsc_active", 1'b0, 1'b1, 5'd7, -6'sd32, 5'd16, 5'd7, 1'b0, 1'b0);
    endtask

    task automatic test_pal();
        run_line("pal_line1", 1'b1, 1'b1, 5'd3, -6'sd5, 5'd20, 5'd29, 1'b1, 1'b0);
        run_line("pal_line2", 1'b1, 1'b1, 5'd3, -6'sd5, 5'd12, 5'd3,  1'b0, 1'b0);
        run_line("pal_line3", 1'b1, 1'b1, 5'd3, -6'sd5, 5'd20, 5'd29, 1'b1, 1'b0);
        run_line("pal_line4", 1'b1, 1'b1, 5'd3, -6'sd5, 5'd12, 5'd3,  1'b0, 1'b0);
        run_line("pal_hue0",  1'b1, 1'b1, 5'd0, 6'sd31, 5'd20, 5'd0,  1'b1, 1'b0);
    endtask

    // vsw=1 and acc nonzero on entry; frame_start must win over the toggle.
    task automatic test_frame_line();
        run_line("frame_line", 1'b1, 1'b0, 5'd0, 6'sd0, 5'd12, 5'd0, 1'b0, 1'b1);
    endtask

    task automatic test_wrap();
        logic [4:0] ep;
        phase_inc = 32'hF800_0000; pal_mode = 1'b0; line_start = 1'b1;
        frame_start = 1'b1; active = 1'b0;
        tick();
        line_start = 1'b0; frame_start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 10) phase_inc = 32'h0800_0000;
            ep = 5'd0 - 5'(k - 1);
            tick();
            checks++;
            if (phase !== ep || amplitude !== 6'sd0 || burst !== 1'b0) begin
                failures++;
                $display("FAIL wrap k=%0d got phase=%0d amp=%0d burst=%0b exp phase=%0d amp=0 burst=0",
                         k, phase, amplitude, burst, ep);
            end
        end
    endtask

    task automatic test_reset_in_burst();
        phase_inc = 32'h0800_0000; pal_mode = 1'b0; line_start = 1'b1;
        frame_start = 1'b1; active = 1'b0;
        tick();
        line_start = 1'b0; frame_start = 1'b0;
        repeat (90) tick();
        checks++;
        if (burst !== 1'b1 || amplitude !== 6'sd12 || phase !== 5'd9) begin
            failures++;
            $display("FAIL pre_reset_burst got phase=%0d amp=%0d burst=%0b exp 9/12/1",
                     phase, amplitude, burst);
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (burst !== 1'b0 || amplitude !== 6'sd0 || phase !== 5'd0 || v_switch !== 1'b0) begin
            failures++;
            $display("FAIL async_reset got phase=%0d amp=%0d burst=%0b vsw=%0b exp 0/0/0/0",
                     phase, amplitude, burst, v_switch);
        end
        tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            checks++;
            if (burst !== 1'b0 || amplitude !== 6'sd0 || phase !== 5'd0) begin
                failures++;
                $display("FAIL post_reset k=%0d got phase=%0d amp=%0d burst=%0b exp 0/0/0",
                         k, phase, amplitude, burst);
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        mph = '0;
        test_reset();
        test_ntsc();
        test_pal();
        test_frame_line();
        test_wrap();
        test_reset_in_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/chroma_phase_gen.md
# chroma_phase_gen

Generates the per-clock phase and signed amplitude that drive the sine LUT stage of the composite encoder's chroma path. A phase accumulator runs at the subcarrier rate. Colour burst is inserted at a fixed position in each line, and hue/saturation are applied during active video. PAL V-switch alternation is included. Outputs are registered and connect directly to the LUT's `phase` / `amplitude` inputs.

## Interface

- `ACC_WIDTH`, 32: phase accumulator width; output phase is the top 5 bits.
- `CNT_WIDTH`, 11: line cycle counter width.
- `BURST_START`, 80: line counter value of the first burst cycle.
- `BURST_LEN`, 40: burst duration in clocks.
- `BURST_AMP`, 12: burst amplitude, positive, at most 31.

- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `phase_inc`  in  ACC_WIDTH  accumulator increment per clock; latched on `line_start`.
- `pal_mode`  in  1  1 = PAL, 0 = NTSC; latched on `line_start`.
- `line_start`  in  1  one-clock pulse at the start of each line.
- `frame_start`  in  1  one-clock pulse at the start of each frame.
- `active`  in  1  high during the active pixel region.
- `hue`  in  5  chroma phase offset in 11.25° steps.
- `saturation`  in  signed 6  chroma amplitude, range -31..31.
- `phase`  out  5  subcarrier phase to the LUT.
- `amplitude`  out  signed 6  amplitude to the LUT.
- `burst`  out  1  high while burst is being emitted.
- `v_switch`  out  1  current PAL V-switch state.

## Operation

- Internal state:
  - `acc` (ACC_WIDTH bits).
  - `cnt` (CNT_WIDTH bits, saturating).
  - `inc_l` (latched increment).
  - `pal_l` (latched mode).
  - `vsw` (V-switch).
- Accumulator:
  - `acc <= acc + inc_l` every clock, wrapping modulo 2^ACC_WIDTH.
  - `frame_start` loads `acc <= 0` instead of adding.
  - `acc_ph = acc[ACC_WIDTH-1 -: 5]`.
- Line counter:
  - `line_start` or `frame_start` loads `cnt <= 0`.
  - Otherwise `cnt` increments and saturates at all-ones; it never wraps.
- Latching:
  - On `line_start`: `inc_l <= phase_inc` and `pal_l <= pal_mode`.
  - Mid-line changes of `phase_inc` / `pal_mode` are ignored.
- V-switch:
  - On `line_start`: `vsw <= pal_mode ? ~vsw : 0`, using the incoming `pal_mode`.
  - `frame_start` forces `vsw <= 0` and takes precedence over `line_start` in the same cycle.
- Output selection, evaluated each cycle from current state and inputs, priority order:
  1. Burst window, `BURST_START <= cnt < BURST_START+BURST_LEN`:
     - `amplitude = BURST_AMP`, `burst = 1`.
     - `phase = acc_ph + off`, where `off` = 16 (180°) in NTSC, 12 (135°) in PAL with `vsw`=0, 20 (225°) in PAL with `vsw`=1.
  2. `active`:
     - `amplitude = saturation`, `burst = 0`.
     - `phase = acc_ph + (pal_l && vsw ? -hue : hue)`.
  3. Otherwise: `amplitude = 0`, `phase = acc_ph`, `burst = 0`.
- Arithmetic rules:
  - All 5-bit phase arithmetic is modulo 32.
  - `-hue` is the 5-bit two's complement, so `-0` = 0.
  - `saturation` passes through unmodified, including -32.
- `v_switch` output = `vsw`.

## Timing

- Reset values, held while `rst_n`=0:
  - `acc` 0, `inc_l` 0, `pal_l` 0, `vsw` 0.
  - `cnt` all-ones, so there is no burst before the first `line_start`.
  - `phase` 0, `amplitude` 0, `burst` 0, `v_switch` 0.
- Reset is asynchronous in both assertion and release; all state is cleared mid-line if reset asserts.
- Latency: all outputs are registered.
  - Inputs, `cnt` and `acc` present during cycle k are reflected after the rising edge ending cycle k.
  - Total chroma latency through this block plus the LUT is 3 clocks.
- `line_start` sampled at edge e gives `cnt`=0 after e.
  - The first burst output appears after edge e+BURST_START+1.
  - The last burst output appears after edge e+BURST_START+BURST_LEN.
- A new `inc_l` takes effect on the accumulator update one edge after `line_start` is sampled.
- `line_start` during a burst aborts the burst: `cnt` restarts at 0.
- `active` overlapping the burst window is ignored; burst wins.

## Test plan

- Reset, then hold `rst_n`=1 with no `line_start` for 3000 clocks -> `burst` stays 0, `amplitude`=0, `phase` stays 0 (`inc_l`=0).
- NTSC: `phase_inc`=0x0800_0000, `pal_mode`=0, one `line_start` ->
  - `phase` steps by +1 every clock;
  - `burst` is high for exactly 40 clocks starting 81 clocks after the pulse edge;
  - during burst `phase` = `acc_ph`+16 and `amplitude`=12.
- PAL: four consecutive lines ->
  - `v_switch` reads 1, 0, 1, 0;
  - burst offset reads 20, 12, 20, 12;
  - with `active`=1, `hue`=3, `saturation`=-5: `phase` = `acc_ph`+29 on odd lines and `acc_ph`+3 on even lines, `amplitude`=-5.
- `frame_start` and `line_start` in the same cycle with `vsw`=1, `acc`≠0 -> after the edge `vsw`=0, `acc`=0, `cnt`=0.
- Wrap: `phase_inc`=0xF800_0000 -> `phase` decrements by 1 per clock (31→30…, 0→31). Changing `phase_inc` mid-line has no effect until the next `line_start`.
- Assert `rst_n`=0 during burst -> `burst`/`amplitude`/`phase` go to 0 immediately, without waiting for a clock edge.
